// File: rtl/spwm_pkg.sv
// Shared types and constants for the SPWM gate generator.
//   SAMPLE_W        : width of reference samples and carrier
//   DEAD_W          : width of the dead-time counter
//   *_DEF           : default generics for the top level
//   dt_state_e      : dead-time FSM state encoding
package spwm_pkg;

  localparam int unsigned SAMPLE_W        = 12;
  localparam int unsigned DEAD_W          = 8;
  localparam int unsigned CARRIER_MAX_DEF = 1638;
  localparam int unsigned DEAD_TIME_DEF   = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    HI_ON = 3'd1,
    DT_HL = 3'd2,
    LO_ON = 3'd3,
    DT_LH = 3'd4
  } dt_state_e;

endpackage

// File: rtl/spwm_gate_gen_if.sv
// Signal bundle between the controller and the SPWM gate generator.
//   en      : gate enable (master -> slave)
//   ref_in  : modulating sample, one per clock (master -> slave)
//   carrier : triangular carrier value (slave -> master)
//   sync    : carrier valley marker (slave -> master)
//   gate_h  : high-side gate drive (slave -> master)
//   gate_l  : low-side gate drive (slave -> master)
interface spwm_gate_gen_if;
  import spwm_pkg::*;

  logic    en;
  sample_t ref_in;
  sample_t carrier;
  logic    sync;
  logic    gate_h;
  logic    gate_l;

  modport master (output en, ref_in, input carrier, sync, gate_h, gate_l);
  modport slave  (input en, ref_in, output carrier, sync, gate_h, gate_l);

endinterface

// File: rtl/spwm_deadtime.sv
// Dead-time inserter: turns the raw PWM comparison into complementary
// gate drives with DEAD_TIME idle cycles at every hand-over.
//   clk_in, rst_n : clock, async active-low reset
//   pwm_raw       : raw comparator output (1 = high side wanted)
//   en            : enable; 0 drops to OFF on the next edge
//   gate_h/gate_l : registered gate drives, never both high
module spwm_deadtime
  import spwm_pkg::*;
#(
  parameter int unsigned DEAD_TIME = DEAD_TIME_DEF
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic pwm_raw,
  input  logic en,
  output logic gate_h,
  output logic gate_l
);

  localparam logic [DEAD_W-1:0] DT_LOAD = DEAD_W'(DEAD_TIME);
  localparam logic [DEAD_W-1:0] DT_ONE  = DEAD_W'(1);

  dt_state_e         state;
  logic [DEAD_W-1:0] dead_cnt;

  // State, counter and gates update together so the gates are pure flops.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      dead_cnt <= '0;
      gate_h   <= 1'b0;
      gate_l   <= 1'b0;
    end else if (!en) begin
      state    <= OFF;
      dead_cnt <= '0;
      gate_h   <= 1'b0;
      gate_l   <= 1'b0;
    end else begin
      unique case (state)
        OFF: begin
          state    <= DT_LH;
          dead_cnt <= DT_LOAD;
          gate_h   <= 1'b0;
          gate_l   <= 1'b0;
        end
        HI_ON: begin
          if (!pwm_raw) begin
            state    <= DT_HL;
            dead_cnt <= DT_LOAD;
            gate_h   <= 1'b0;
          end
        end
        LO_ON: begin
          if (pwm_raw) begin
            state    <= DT_LH;
            dead_cnt <= DT_LOAD;
            gate_l   <= 1'b0;
          end
        end
        DT_HL, DT_LH: begin
          // Exit side is chosen from pwm_raw now, not from the entry edge.
          if (dead_cnt == DT_ONE) begin
            state    <= pwm_raw ? HI_ON : LO_ON;
            dead_cnt <= '0;
            gate_h   <= pwm_raw;
            gate_l   <= !pwm_raw;
          end else begin
            dead_cnt <= dead_cnt - DT_ONE;
          end
        end
        default: begin
          state    <= OFF;
          dead_cnt <= '0;
          gate_h   <= 1'b0;
          gate_l   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/spwm_gate_gen.sv
// Sine-PWM gate generator: triangular carrier, valley-latched reference,
// comparator and dead-time protected complementary gate outputs.
//   clk_in, rst_n : clock, async active-low reset
//   bus (slave)   : en, ref_in in; carrier, sync, gate_h, gate_l out
module spwm_gate_gen
  import spwm_pkg::*;
#(
  parameter int unsigned CARRIER_MAX = CARRIER_MAX_DEF,
  parameter int unsigned DEAD_TIME   = DEAD_TIME_DEF
) (
  input  logic            clk_in,
  input  logic            rst_n,
  spwm_gate_gen_if.slave  bus
);

  localparam sample_t CMAX = SAMPLE_W'(CARRIER_MAX);
  localparam sample_t ONE  = SAMPLE_W'(1);

  sample_t carrier_q;
  sample_t carrier_nxt_c;
  sample_t ref_q;
  logic    dir_up;
  logic    sync_q;
  logic    pwm_raw_c;

  // Next carrier value; the end points force the turn-around directly.
  always_comb begin
    carrier_nxt_c = carrier_q;
    if (carrier_q == '0) begin
      carrier_nxt_c = ONE;
    end else if (carrier_q == CMAX) begin
      carrier_nxt_c = CMAX - ONE;
    end else if (dir_up) begin
      carrier_nxt_c = carrier_q + ONE;
    end else begin
      carrier_nxt_c = carrier_q - ONE;
    end
  end

  // Carrier, direction, valley marker and valley-latched reference.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      carrier_q <= '0;
      dir_up    <= 1'b1;
      sync_q    <= 1'b1;
      ref_q     <= '0;
    end else begin
      carrier_q <= carrier_nxt_c;
      sync_q    <= (carrier_nxt_c == '0);
      if (carrier_q == '0) begin
        dir_up <= 1'b1;
        ref_q  <= (bus.ref_in > CMAX) ? CMAX : bus.ref_in;
      end else if (carrier_q == CMAX) begin
        dir_up <= 1'b0;
      end
    end
  end

  assign pwm_raw_c   = (ref_q > carrier_q);
  assign bus.carrier = carrier_q;
  assign bus.sync    = sync_q;

  spwm_deadtime #(
    .DEAD_TIME (DEAD_TIME)
  ) u_deadtime (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .pwm_raw (pwm_raw_c),
    .en      (bus.en),
    .gate_h  (bus.gate_h),
    .gate_l  (bus.gate_l)
  );

endmodule

// File: doc/spwm_gate_gen.md
SPWM_GATE_GEN -- requirements
Module: spwm_gate_gen

Interface
REQ-001 Parameter CARRIER_MAX, default 1638, triangular carrier peak value, 12-bit, range 16..4095.
REQ-002 Parameter DEAD_TIME, default 8, dead-time length in clk_in cycles, 8-bit, range 1..255.
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  gate enable; 0 forces both gates low.
REQ-006 ref_in  input  12  modulating sample from the upstream sine LUT, new value every clk_in cycle, unsigned.
REQ-007 carrier  output  12  current triangular carrier value.
REQ-008 sync  output  1  one-cycle pulse marking a carrier valley.
REQ-009 gate_h  output  1  high-side gate drive.
REQ-010 gate_l  output  1  low-side gate drive.

Function
REQ-011 The carrier counter shall count up 0..CARRIER_MAX, then down to 0, then repeat, giving a period of 2*CARRIER_MAX cycles and holding no value twice in a row.
REQ-012 The direction shall flip on the cycle where carrier reaches CARRIER_MAX (next value CARRIER_MAX-1) and where it reaches 0 (next value 1).
REQ-013 sync shall be 1 exactly in cycles where carrier==0.
REQ-014 ref_q (12-bit register) shall load min(ref_in, CARRIER_MAX) on the clock edge at which carrier==0; it holds otherwise, so mid-period ref_in changes apply only from the next valley.
REQ-015 pwm_raw shall be the combinational result (ref_q > carrier).
REQ-016 The dead-time FSM shall have states OFF, HI_ON, DT_HL, LO_ON, DT_LH.
REQ-017 In HI_ON, gate_h=1 and gate_l=0; in LO_ON, gate_h=0 and gate_l=1; in OFF, DT_HL and DT_LH, both gates are 0.
REQ-018 OFF with en=1 shall go to DT_LH and load the dead counter with DEAD_TIME.
REQ-019 HI_ON with pwm_raw=0 shall go to DT_HL and load DEAD_TIME.
REQ-020 LO_ON with pwm_raw=1 shall go to DT_LH and load DEAD_TIME.
REQ-021 In a DT state, the counter shall decrement each cycle; when it reaches 1, the next state shall be HI_ON if pwm_raw=1, else LO_ON (decided on the current pwm_raw, not the edge that caused entry).
REQ-022 Each dead interval shall therefore be exactly DEAD_TIME cycles, and pwm_raw pulses shorter than DEAD_TIME may be swallowed.
REQ-023 en=0 in any state shall move the FSM to OFF on the next edge, with both gates 0 from that edge; the carrier and ref_q keep running.
REQ-024 gate_h and gate_l shall be driven directly from registered state, with no combinational path from ref_in or en.
REQ-025 gate_h and gate_l shall never be 1 in the same cycle, under any input sequence.

Reset
REQ-026 While rst_n=0, outputs shall be: carrier=0, direction=up, ref_q=0, dead counter=0, state=OFF, gate_h=0, gate_l=0, sync=1 (carrier==0).
REQ-027 Reset assertion shall clear the gates immediately, without a clock edge, including mid-dead-time.
REQ-028 After rst_n deasserts, the first edge shall advance carrier to 1.

Structure
REQ-029 Package spwm_pkg shall hold the FSM state encoding, the 12-bit sample width constant, and the CARRIER_MAX and DEAD_TIME defaults.
REQ-030 The dead-time FSM and counter shall be sub-module spwm_deadtime (inputs pwm_raw, en; outputs gate_h, gate_l); the carrier, sync and ref_q stay in the top level.

Verification (CARRIER_MAX=16, DEAD_TIME=2)
REQ-031 en=1, ref_in=8 constant -> period 32 cycles, sync every 32 cycles, pwm_raw high 15 cycles per period, gate_h high 13, gate_l high 15, both low 4.
REQ-032 ref_in=0 -> after the initial 2 dead cycles, gate_l stays 1 and gate_h stays 0.
REQ-033 ref_in=4095 -> ref_q=16; each period, gate_h drops for exactly 2 cycles around carrier=16, and gate_l never rises.
REQ-034 ref_in changes 8->12 at carrier=5 (rising) -> duty unchanged until the next sync, then gate_h high 21 cycles per period.
REQ-035 en dropped during HI_ON -> both gates 0 on the next edge; en reasserted -> both gates 0 for 2 cycles, then the gate matching pwm_raw goes high.
REQ-036 rst_n pulsed low mid-DT_HL, between clock edges -> gates 0 at once and carrier=0; an assertion checks that gate_h and gate_l are never both 1 across all runs.
